// File: rtl/vmem_uop_sequencer.sv
// Fetch-side micro-op sequencer: scalar instructions pass straight through,
// vector loads/stores are expanded into one scalar micro-op per element.
//
// state | meaning
// IDLE  | output slot free to take a new instruction from fetch
// ISSUE | emitting the remaining elements of a latched vector op
module vmem_uop_sequencer #(
  parameter int unsigned MAX_VLEN = 8,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned OFF_W    = 16,
  parameter bit          DESCEND  = 1'b1,
  parameter logic [5:0]  OP_LW_V  = 6'h30,
  parameter logic [5:0]  OP_SW_V  = 6'h38,
  parameter logic [5:0]  OP_LWS_V = 6'h31,
  parameter logic [5:0]  OP_SWS_V = 6'h39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instn_in,
  input  logic [31:0]      vlen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instn,
  output logic [IDX_W-1:0] out_elem_idx,
  output logic [OFF_W-1:0] out_offset,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned PROD_W = IDX_W + 6;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [5:0]       stride_q, stride_d;
  logic [19:0]      body_q, body_d;
  logic [5:0]       funct_q, funct_d;

  logic             out_valid_d, out_last_d;
  logic [31:0]      out_instn_d;
  logic [IDX_W-1:0] idx_d;
  logic [OFF_W-1:0] off_d;

  logic             adv, accept, is_vec, is_strided;
  logic [5:0]       opcode, in_stride;
  logic [31:0]      eff_len;
  logic [IDX_W-1:0] first_idx, step_idx;

  function automatic logic [OFF_W-1:0] elem_offset(input logic [IDX_W-1:0] idx,
                                                   input logic [5:0] stride);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(idx) * PROD_W'(stride);
    return OFF_W'(prod);
  endfunction

  // Micro-op: opcode MSB cleared gives the scalar counterpart, shamt carries the index.
  function automatic logic [31:0] make_uop(input logic [19:0] body,
                                           input logic [IDX_W-1:0] idx,
                                           input logic [5:0] funct);
    return {1'b0, body, 5'(idx), funct};
  endfunction

  assign opcode     = instn_in[31:26];
  assign is_strided = (opcode == OP_LWS_V) || (opcode == OP_SWS_V);
  assign is_vec     = is_strided || (opcode == OP_LW_V) || (opcode == OP_SW_V);
  assign eff_len    = (vlen > 32'(MAX_VLEN)) ? 32'(MAX_VLEN) : vlen;
  assign in_stride  = is_strided ? instn_in[5:0] : 6'd1;
  assign first_idx  = DESCEND ? IDX_W'(eff_len - 32'd1) : '0;
  assign step_idx   = DESCEND ? out_elem_idx - IDX_W'(1) : out_elem_idx + IDX_W'(1);

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state_q == IDLE) && adv && !flush;
  assign accept   = in_ready && in_valid;
  assign busy     = (state_q == ISSUE);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stride_d    = stride_q;
    body_d      = body_q;
    funct_d     = funct_q;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_instn_d = out_instn;
    idx_d       = out_elem_idx;
    off_d       = out_offset;

    if (flush) begin
      state_d     = IDLE;
      rem_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (adv) begin
      case (state_q)
        IDLE: begin
          if (!accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else if (!is_vec) begin
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_instn_d = instn_in;
            idx_d       = '0;
            off_d       = '0;
          end else if (eff_len == 32'd0) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            body_d      = instn_in[30:11];
            funct_d     = instn_in[5:0];
            stride_d    = in_stride;
            out_valid_d = 1'b1;
            out_instn_d = make_uop(instn_in[30:11], first_idx, instn_in[5:0]);
            idx_d       = first_idx;
            off_d       = elem_offset(first_idx, in_stride);
            rem_d       = IDX_W'(eff_len - 32'd1);
            if (eff_len > 32'd1) begin
              state_d    = ISSUE;
              out_last_d = 1'b0;
            end else begin
              out_last_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          out_valid_d = 1'b1;
          out_instn_d = make_uop(body_q, step_idx, funct_q);
          idx_d       = step_idx;
          off_d       = elem_offset(step_idx, stride_q);
          rem_d       = rem_q - IDX_W'(1);
          if (rem_q == IDX_W'(1)) begin
            out_last_d = 1'b1;
            state_d    = IDLE;
          end else begin
            out_last_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      stride_q     <= '0;
      body_q       <= '0;
      funct_q      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_instn    <= '0;
      out_elem_idx <= '0;
      out_offset   <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      stride_q     <= stride_d;
      body_q       <= body_d;
      funct_q      <= funct_d;
      out_valid    <= out_valid_d;
      out_last     <= out_last_d;
      out_instn    <= out_instn_d;
      out_elem_idx <= idx_d;
      out_offset   <= off_d;
    end
  end

endmodule

// File: tb/tb_vmem_uop_sequencer.sv
// Bench for vmem_uop_sequencer: descending and ascending instances share the
// stimulus; a per-instance queue model of expanded micro-ops is checked every cycle.
module tb_vmem_uop_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instn_in, vlen;

  logic        rdy[2], ov[2], olast[2], obusy[2];
  logic [31:0] oins[2];
  logic [4:0]  oidx[2];
  logic [15:0] ooff[2];

  int n_chk = 0;
  int n_fail = 0;

  vmem_uop_sequencer #(.DESCEND(1'b1)) u_desc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .instn_in(instn_in), .vlen(vlen), .out_valid(ov[0]), .out_ready(out_ready),
    .out_instn(oins[0]), .out_elem_idx(oidx[0]), .out_offset(ooff[0]),
    .out_last(olast[0]), .busy(obusy[0]));

  vmem_uop_sequencer #(.DESCEND(1'b0)) u_asc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .instn_in(instn_in), .vlen(vlen), .out_valid(ov[1]), .out_ready(out_ready),
    .out_instn(oins[1]), .out_elem_idx(oidx[1]), .out_offset(ooff[1]),
    .out_last(olast[1]), .busy(obusy[1]));

  always #5 clk = ~clk;

  // Model: output slot plus a queue of not-yet-issued micro-ops (k=0 descending).
  bit          m_valid[2], m_last[2], m_acc, chk_en;
  logic [31:0] m_instn[2];
  int          m_idx[2], m_off[2];
  logic [31:0] p_instn[2][16];
  int          p_idx[2][16], p_off[2][16];
  bit          p_last[2][16];
  int          p_n[2], p_p[2];

  logic [31:0] l_instn[2][256];
  int          l_idx[2][256], l_off[2][256];
  bit          l_last[2][256];
  int          l_n[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit mdl_is_vec(input logic [31:0] i);
    return i[31:26] inside {6'h30, 6'h38, 6'h31, 6'h39};
  endfunction

  task automatic expand(input int k, input logic [31:0] i, input logic [31:0] vl);
    int len, stride, id;
    len = (vl > 32'd8) ? 8 : int'(vl);
    stride = (i[31:26] == 6'h31 || i[31:26] == 6'h39) ? int'(i[5:0]) : 1;
    for (int e = 0; e < len; e++) begin
      id = (k == 0) ? len - 1 - e : e;
      p_instn[k][e] = {1'b0, i[30:11], 5'(id), i[5:0]};
      p_idx[k][e]   = id;
      p_off[k][e]   = (id * stride) % 65536;
      p_last[k][e]  = (e == len - 1);
    end
    p_n[k] = len;
    p_p[k] = 0;
  endtask

  task automatic pop(input int k);
    m_valid[k] = 1'b1;
    m_instn[k] = p_instn[k][p_p[k]];
    m_idx[k]   = p_idx[k][p_p[k]];
    m_off[k]   = p_off[k][p_p[k]];
    m_last[k]  = p_last[k][p_p[k]];
    p_p[k]++;
  endtask

  task automatic model_step();
    bit adv, acc;
    for (int k = 0; k < 2; k++) begin
      adv = !m_valid[k] || out_ready;
      acc = (p_p[k] == p_n[k]) && adv && !flush && in_valid && !rst;
      if (k == 0) m_acc = acc;
      if (rst) begin
        m_valid[k] = 0; m_last[k] = 0; m_instn[k] = 0; m_idx[k] = 0; m_off[k] = 0;
        p_n[k] = 0; p_p[k] = 0;
      end else if (flush) begin
        m_valid[k] = 0; m_last[k] = 0; p_n[k] = 0; p_p[k] = 0;
      end else if (adv) begin
        if (p_p[k] < p_n[k]) pop(k);
        else if (acc && mdl_is_vec(instn_in)) begin
          expand(k, instn_in, vlen);
          if (p_n[k] > 0) pop(k);
          else begin m_valid[k] = 0; m_last[k] = 0; end
        end else if (acc) begin
          m_valid[k] = 1; m_last[k] = 1; m_instn[k] = instn_in; m_idx[k] = 0; m_off[k] = 0;
        end else begin
          m_valid[k] = 0; m_last[k] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_valid[k]));
      chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]),
          32'((p_p[k] == p_n[k]) && (!m_valid[k] || out_ready) && !flush));
      chk($sformatf("busy[%0d]", k), 32'(obusy[k]), 32'(p_p[k] < p_n[k]));
      chk($sformatf("out_last[%0d]", k), 32'(olast[k]), 32'(m_last[k]));
      if (m_valid[k]) begin
        chk($sformatf("out_instn[%0d]", k), oins[k], m_instn[k]);
        chk($sformatf("out_elem_idx[%0d]", k), 32'(oidx[k]), 32'(m_idx[k]));
        chk($sformatf("out_offset[%0d]", k), 32'(ooff[k]), 32'(m_off[k]));
      end
      if (ov[k] === 1'b1 && out_ready && l_n[k] < 256) begin
        l_instn[k][l_n[k]] = oins[k];
        l_idx[k][l_n[k]]   = int'(oidx[k]);
        l_off[k][l_n[k]]   = int'(ooff[k]);
        l_last[k][l_n[k]]  = olast[k];
        l_n[k]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_en) compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] vl, output int ncyc);
    in_valid = 1'b1; instn_in = ins; vlen = vl; ncyc = 0;
    do begin
      cycle();
      ncyc++;
    end while (!m_acc && ncyc < 50);
    chk("send_accepted", 32'(m_acc), 32'd1);
    in_valid = 1'b0; instn_in = 32'h0; vlen = 32'd1;
  endtask

  task automatic drain();
    int c = 0;
    while ((p_p[0] < p_n[0] || p_p[1] < p_n[1] || m_valid[0] || m_valid[1]) && c < 40) begin
      cycle();
      c++;
    end
    chk("drain_timeout", 32'(c >= 40), 32'd0);
  endtask

  task automatic chk_log(input int k, input int pos, input logic [31:0] ins,
                         input int id, input int off, input bit last);
    chk($sformatf("log%0d_%0d_instn", k, pos), l_instn[k][pos], ins);
    chk($sformatf("log%0d_%0d_idx", k, pos), 32'(l_idx[k][pos]), 32'(id));
    chk($sformatf("log%0d_%0d_off", k, pos), 32'(l_off[k][pos]), 32'(off));
    chk($sformatf("log%0d_%0d_last", k, pos), 32'(l_last[k][pos]), 32'(last));
  endtask

  task automatic chk_reset_outputs(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_valid"}, 32'(ov[k]), 32'd0);
      chk({nm, "_instn"}, oins[k], 32'd0);
      chk({nm, "_idx"}, 32'(oidx[k]), 32'd0);
      chk({nm, "_off"}, 32'(ooff[k]), 32'd0);
      chk({nm, "_last"}, 32'(olast[k]), 32'd0);
      chk({nm, "_busy"}, 32'(obusy[k]), 32'd0);
    end
  endtask

  localparam logic [31:0] SCALAR = 32'h0123_4820;
  localparam logic [31:0] VLOAD  = 32'hC022_1800;
  localparam logic [31:0] VSSTR  = 32'hE444_0004;

  initial begin
    int n, b0, b1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instn_in = 32'h0; vlen = 32'h0; chk_en = 1'b0;
    run(2);
    rst = 1'b0; chk_en = 1'b1;
    chk_reset_outputs("reset");

    b0 = l_n[0];
    send(SCALAR, 32'd5, n);
    drain();
    chk("scalar_count", 32'(l_n[0] - b0), 32'd1);
    chk_log(0, b0, SCALAR, 0, 0, 1'b1);

    b0 = l_n[0]; b1 = l_n[1];
    send(VLOAD, 32'd4, n);
    drain();
    chk("unit_desc_count", 32'(l_n[0] - b0), 32'd4);
    chk("unit_asc_count", 32'(l_n[1] - b1), 32'd4);
    chk_log(0, b0,     32'h4022_18C0, 3, 3, 1'b0);
    chk_log(0, b0 + 1, 32'h4022_1880, 2, 2, 1'b0);
    chk_log(0, b0 + 2, 32'h4022_1840, 1, 1, 1'b0);
    chk_log(0, b0 + 3, 32'h4022_1800, 0, 0, 1'b1);
    chk_log(1, b1 + 3, 32'h4022_18C0, 3, 3, 1'b1);

    b0 = l_n[0]; b1 = l_n[1];
    send(VSSTR, 32'd3, n);
    drain();
    chk("strided_count", 32'(l_n[1] - b1), 32'd3);
    chk_log(1, b1,     32'h6444_0004, 0, 0, 1'b0);
    chk_log(1, b1 + 1, 32'h6444_0044, 1, 4, 1'b0);
    chk_log(1, b1 + 2, 32'h6444_0084, 2, 8, 1'b1);
    chk_log(0, b0,     32'h6444_0084, 2, 8, 1'b0);

    b0 = l_n[0]; b1 = l_n[1];
    send(VLOAD, 32'h0000_0100, n);
    drain();
    chk("clamp_desc_count", 32'(l_n[0] - b0), 32'd8);
    chk("clamp_asc_count", 32'(l_n[1] - b1), 32'd8);
    chk_log(0, b0, 32'h4022_19C0, 7, 7, 1'b0);
    chk_log(1, b1 + 7, 32'h4022_19C0, 7, 7, 1'b1);

    b0 = l_n[0];
    send(VLOAD, 32'd0, n);
    chk("zero_len_out_valid", 32'(ov[0]), 32'd0);
    send(SCALAR, 32'd0, n);
    chk("zero_len_next_accept_cycles", 32'(n), 32'd1);
    drain();
    chk("zero_len_count", 32'(l_n[0] - b0), 32'd1);
    chk_log(0, b0, SCALAR, 0, 0, 1'b1);

    b0 = l_n[0];
    send(VLOAD, 32'd2, n);
    send(SCALAR, 32'd0, n);
    chk("b2b_accept_cycles", 32'(n), 32'd2);
    drain();
    chk("b2b_count", 32'(l_n[0] - b0), 32'd3);

    b0 = l_n[0];
    send(VLOAD, 32'd4, n);
    run(2);
    out_ready = 1'b0;
    run(2);
    chk("bp_hold_valid", 32'(ov[0]), 32'd1);
    chk("bp_hold_idx", 32'(oidx[0]), 32'd1);
    out_ready = 1'b1;
    drain();
    chk("bp_count", 32'(l_n[0] - b0), 32'd4);
    chk_log(0, b0 + 2, 32'h4022_1840, 1, 1, 1'b0);
    chk_log(0, b0 + 3, 32'h4022_1800, 0, 0, 1'b1);

    send(VLOAD, 32'd8, n);
    run(2);
    flush = 1'b1; in_valid = 1'b1; instn_in = SCALAR;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(ov[0]), 32'd0);
    chk("flush_busy", 32'(obusy[0]), 32'd0);
    chk("flush_out_valid_asc", 32'(ov[1]), 32'd0);
    b0 = l_n[0];
    send(SCALAR, 32'd0, n);
    chk("flush_next_accept_cycles", 32'(n), 32'd1);
    drain();
    chk("flush_count", 32'(l_n[0] - b0), 32'd1);

    send(VLOAD, 32'd8, n);
    run(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk_reset_outputs("mid_rst");
    b0 = l_n[0];
    send(SCALAR, 32'd0, n);
    drain();
    chk("post_rst_count", 32'(l_n[0] - b0), 32'd1);
    chk_log(0, b0, SCALAR, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
